// File: rtl/uart_tx_stream.sv
// Streams FIFO bytes into the UART transmit register and shares the
// register port with a one-deep pending host access slot.
module uart_tx_stream #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] TIMEOUT  = 16'hFFFF,
    parameter logic [15:0] TRS_ADDR = 16'h000C,
    parameter logic [15:0] INT_ADDR = 16'h0010
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    input  logic        stream_en,
    input  logic        flush,
    input  logic        host_req,
    input  logic        host_wr,
    input  logic [15:0] host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic [15:0] u_addr,
    output logic        u_cs_n,
    output logic        u_wr_n,
    output logic        u_rd_n,
    output logic [7:0]  u_wdata,
    input  logic [7:0]  u_rdata,
    input  logic        u_ti,
    output logic        busy,
    output logic        timeout_err,
    output logic [4:0]  fifo_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH5 = 5'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_TRS,
        S_WAIT_TI,
        S_CLR_TI,
        S_GAP,
        S_HOST
    } state_t;

    state_t state_q, state_d;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [4:0]    cnt_q, cnt_d;

    logic          pend_q, pend_d;
    logic          pend_wr_q, pend_wr_d;
    logic [15:0]   pend_addr_q, pend_addr_d;
    logic [7:0]    pend_wdata_q, pend_wdata_d;
    logic          host_rd_q, host_rd_d;
    logic          ret_wait_q, ret_wait_d;

    logic [15:0]   tmo_q, tmo_d;
    logic          terr_q, terr_d;

    logic [15:0]   u_addr_q, u_addr_d;
    logic          u_cs_n_q, u_cs_n_d;
    logic          u_wr_n_q, u_wr_n_d;
    logic          u_rd_n_q, u_rd_n_d;
    logic [7:0]    u_wdata_q, u_wdata_d;
    logic          ack_q, ack_d;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic start_byte;
    logic tmo_hit;
    logic wait_done;
    logic issue_host;
    logic counting;

    assign fifo_empty = (cnt_q == 5'd0);
    assign fifo_full  = (cnt_q == DEPTH5);
    assign push       = s_valid && !fifo_full && !flush;

    assign start_byte = (state_q == S_IDLE) && !pend_q
                        && stream_en && !fifo_empty;

    assign tmo_hit   = ({1'b0, tmo_q} + 17'd1) >= {1'b0, TIMEOUT};
    assign wait_done = (state_q == S_WAIT_TI) && (u_ti || tmo_hit);

    // Host only gets the port when the streamer has nothing due this cycle.
    assign issue_host = pend_q && ((state_q == S_IDLE)
                        || ((state_q == S_WAIT_TI) && !wait_done));

    assign counting = (state_q == S_WAIT_TI)
                      || ((state_q == S_HOST) && ret_wait_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    state_d = S_HOST;
                end else if (start_byte) begin
                    state_d = S_WR_TRS;
                end
            end
            S_WR_TRS:  state_d = S_WAIT_TI;
            S_WAIT_TI: begin
                if (wait_done) begin
                    state_d = S_CLR_TI;
                end else if (pend_q) begin
                    state_d = S_HOST;
                end
            end
            S_CLR_TI:  state_d = S_GAP;
            S_GAP:     state_d = S_IDLE;
            S_HOST:    state_d = ret_wait_q ? S_WAIT_TI : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Port outputs are set up one cycle ahead so they leave on flops.
    always_comb begin
        u_addr_d  = u_addr_q;
        u_wdata_d = u_wdata_q;
        u_cs_n_d  = 1'b1;
        u_wr_n_d  = 1'b1;
        u_rd_n_d  = 1'b1;
        ack_d     = (state_q == S_HOST);
        if (start_byte) begin
            u_cs_n_d  = 1'b0;
            u_wr_n_d  = 1'b0;
            u_addr_d  = TRS_ADDR;
            u_wdata_d = mem_q[rp_q];
        end else if (wait_done) begin
            u_cs_n_d  = 1'b0;
            u_wr_n_d  = 1'b0;
            u_addr_d  = INT_ADDR;
            u_wdata_d = 8'h00;
        end else if (issue_host) begin
            u_cs_n_d  = 1'b0;
            u_wr_n_d  = !pend_wr_q;
            u_rd_n_d  = pend_wr_q;
            u_addr_d  = pend_addr_q;
            if (pend_wr_q) begin
                u_wdata_d = pend_wdata_q;
            end
        end
    end

    always_comb begin
        wp_d         = wp_q;
        rp_d         = rp_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        pend_wr_d    = pend_wr_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        host_rd_d    = host_rd_q;
        ret_wait_d   = ret_wait_q;
        tmo_d        = tmo_q;
        terr_d       = terr_q;

        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = 5'd0;
        end else begin
            if (push) begin
                wp_d = wp_q + AW'(1);
            end
            if (start_byte) begin
                rp_d = rp_q + AW'(1);
            end
            cnt_d = cnt_q + 5'(push) - 5'(start_byte);
        end

        if (issue_host) begin
            pend_d     = 1'b0;
            host_rd_d  = !pend_wr_q;
            ret_wait_d = (state_q == S_WAIT_TI);
        end else if (host_req && !pend_q) begin
            pend_d       = 1'b1;
            pend_wr_d    = host_wr;
            pend_addr_d  = host_addr;
            pend_wdata_d = host_wdata;
        end

        if (state_q == S_WR_TRS) begin
            tmo_d = 16'd0;
        end else if (counting && (tmo_q != TIMEOUT)) begin
            tmo_d = tmo_q + 16'd1;
        end

        if (flush) begin
            terr_d = 1'b0;
        end else if (wait_done && !u_ti) begin
            terr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (push) begin
            mem_q[wp_q] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q         <= '0;
            rp_q         <= '0;
            cnt_q        <= 5'd0;
            pend_q       <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_addr_q  <= 16'h0000;
            pend_wdata_q <= 8'h00;
            host_rd_q    <= 1'b0;
            ret_wait_q   <= 1'b0;
            tmo_q        <= 16'd0;
            terr_q       <= 1'b0;
            u_addr_q     <= 16'h0000;
            u_cs_n_q     <= 1'b1;
            u_wr_n_q     <= 1'b1;
            u_rd_n_q     <= 1'b1;
            u_wdata_q    <= 8'h00;
            ack_q        <= 1'b0;
        end else begin
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_wr_q    <= pend_wr_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            host_rd_q    <= host_rd_d;
            ret_wait_q   <= ret_wait_d;
            tmo_q        <= tmo_d;
            terr_q       <= terr_d;
            u_addr_q     <= u_addr_d;
            u_cs_n_q     <= u_cs_n_d;
            u_wr_n_q     <= u_wr_n_d;
            u_rd_n_q     <= u_rd_n_d;
            u_wdata_q    <= u_wdata_d;
            ack_q        <= ack_d;
        end
    end

    assign u_addr      = u_addr_q;
    assign u_cs_n      = u_cs_n_q;
    assign u_wr_n      = u_wr_n_q;
    assign u_rd_n      = u_rd_n_q;
    assign u_wdata     = u_wdata_q;
    assign host_ack    = ack_q;
    assign host_rdata  = (ack_q && host_rd_q) ? u_rdata : 8'h00;
    assign s_ready     = !fifo_full;
    assign busy        = (state_q != S_IDLE) || !fifo_empty;
    assign timeout_err = terr_q;
    assign fifo_cnt    = cnt_q;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed/randomized bench for uart_tx_stream with a UART register model
// and a port-access log checked against a byte-queue reference.
module tb_uart_tx_stream;

    localparam int DEPTH = 4;
    localparam logic [15:0] TRS = 16'h000C;
    localparam logic [15:0] INTR = 16'h0010;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        stream_en;
    logic        flush;
    logic        host_req;
    logic        host_wr;
    logic [15:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic [15:0] u_addr;
    logic        u_cs_n;
    logic        u_wr_n;
    logic        u_rd_n;
    logic [7:0]  u_wdata;
    logic [7:0]  u_rdata = 8'h00;
    logic        u_ti = 1'b0;
    logic        busy;
    logic        timeout_err;
    logic [4:0]  fifo_cnt;

    uart_tx_stream #(
        .DEPTH(DEPTH),
        .TIMEOUT(16'd20),
        .TRS_ADDR(TRS),
        .INT_ADDR(INTR)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .stream_en(stream_en),
        .flush(flush),
        .host_req(host_req),
        .host_wr(host_wr),
        .host_addr(host_addr),
        .host_wdata(host_wdata),
        .host_ack(host_ack),
        .host_rdata(host_rdata),
        .u_addr(u_addr),
        .u_cs_n(u_cs_n),
        .u_wr_n(u_wr_n),
        .u_rd_n(u_rd_n),
        .u_wdata(u_wdata),
        .u_rdata(u_rdata),
        .u_ti(u_ti),
        .busy(busy),
        .timeout_err(timeout_err),
        .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic        w;
        logic [7:0]  d;
        int          c;
    } acc_t;

    int   cyc = 0;
    acc_t log_q[$];
    int   rd_idx = 0;
    int   viol = 0;
    bit   ti_auto = 1'b0;
    int   ti_delay = 1;
    int   ti_at = -1;
    int   ti_cnt = 0;
    bit   prev_acc = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [7:0] mq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // UART register model: logs accesses, raises ti, returns read data.
    always @(negedge clk) begin
        acc_t e;
        if (!reset_n) begin
            u_ti = 1'b0;
            ti_cnt = 0;
            prev_acc = 1'b0;
        end else begin
            if (ti_cnt > 0) begin
                ti_cnt--;
                if (ti_cnt == 0) u_ti = 1'b1;
            end
            if (cyc == ti_at) u_ti = 1'b1;
            if (!u_cs_n) begin
                if (prev_acc || (u_wr_n == u_rd_n)) viol++;
                e.a = u_addr;
                e.w = !u_wr_n;
                e.d = u_wdata;
                e.c = cyc;
                log_q.push_back(e);
                if (!u_wr_n && u_addr == TRS && ti_auto)
                    ti_cnt = ti_delay;
                if (!u_wr_n && u_addr == INTR && u_wdata == 8'h00)
                    u_ti = 1'b0;
                if (!u_rd_n)
                    u_rdata = (u_addr == 16'h0014) ? 8'h21
                                                   : (u_addr[7:0] ^ 8'h5A);
            end
            prev_acc = !u_cs_n;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk(tag, {u_cs_n, u_wr_n, u_rd_n, u_addr, u_wdata, host_ack,
                  host_rdata, s_ready, busy, timeout_err, fifo_cnt},
            {1'b1, 1'b1, 1'b1, 16'h0000, 8'h00, 1'b0,
             8'h00, 1'b1, 1'b0, 1'b0, 5'd0});
    endtask

    task automatic push_byte(input logic [7:0] b, input bit check,
                             output int n);
        n = cyc;
        s_valid = 1'b1;
        s_data = b;
        if (mq.size() < DEPTH) mq.push_back(b);
        tick(1);
        s_valid = 1'b0;
        if (check) begin
            chk("s_ready", s_ready, mq.size() != DEPTH);
            chk("fifo_cnt", fifo_cnt, mq.size());
        end
    endtask

    task automatic get_acc(input string tag, input int bound,
                           output acc_t e);
        int n = 0;
        while (log_q.size() <= rd_idx && n < bound) begin
            tick(1);
            n++;
        end
        chk({tag, "_seen"}, log_q.size() > rd_idx, 1);
        if (log_q.size() > rd_idx) begin
            e = log_q[rd_idx];
            rd_idx++;
        end else begin
            e.a = 16'hFFFF;
            e.w = 1'b0;
            e.d = 8'h00;
            e.c = 0;
        end
    endtask

    task automatic wait_ack(input string tag, output int c);
        int n = 0;
        while (host_ack !== 1'b1 && n < 10) begin
            tick(1);
            n++;
        end
        chk(tag, host_ack, 1);
        c = cyc;
    endtask

    task automatic host_go(input bit wr, input logic [15:0] a,
                           input logic [7:0] d, output int h);
        h = cyc;
        host_req = 1'b1;
        host_wr = wr;
        host_addr = a;
        host_wdata = d;
        tick(1);
        host_req = 1'b0;
    endtask

    task automatic drain(input int n);
        acc_t t, c;
        for (int i = 0; i < n; i++) begin
            ti_delay = $urandom_range(1, 8);
            get_acc("drain_trs", 60, t);
            chk("drain_trs_addr", {t.w, t.a}, {1'b1, TRS});
            chk("drain_trs_data", t.d, mq.pop_front());
            get_acc("drain_clr", 60, c);
            chk("drain_clr_addr", {c.w, c.a, c.d}, {1'b1, INTR, 8'h00});
            chk("drain_ti_gate", c.c - t.c, ti_delay + 1);
        end
    endtask

    initial begin
        acc_t e;
        int n, t0, h, ac;
        logic [7:0] b;

        reset_n = 1'b0;
        s_valid = 1'b0;
        s_data = 8'h00;
        stream_en = 1'b0;
        flush = 1'b0;
        host_req = 1'b0;
        host_wr = 1'b0;
        host_addr = 16'h0000;
        host_wdata = 8'h00;
        tick(3);
        chk_reset_vals("reset_vals");
        reset_n = 1'b1;
        tick(2);

        // single byte
        stream_en = 1'b1;
        push_byte(8'hA5, 1'b0, n);
        get_acc("single_trs", 10, e);
        chk("single_trs_acc", {e.w, e.a, e.d}, {1'b1, TRS, 8'hA5});
        chk("single_latency", e.c - n, 2);
        void'(mq.pop_front());
        tick(10);
        ti_at = cyc;
        t0 = cyc;
        get_acc("single_clr", 10, e);
        chk("single_clr_acc", {e.w, e.a, e.d}, {1'b1, INTR, 8'h00});
        chk("single_clr_win", (e.c - t0 >= 1) && (e.c - t0 <= 2), 1);
        while (cyc < e.c + 2) tick(1);
        chk("single_idle_busy", busy, 0);

        // fifo full, back-pressure, ordered drain
        stream_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            push_byte(b, 1'b1, n);
        end
        chk("full_model_depth", mq.size(), DEPTH);
        ti_auto = 1'b1;
        stream_en = 1'b1;
        drain(DEPTH);
        tick(3);
        chk("full_drained_cnt", fifo_cnt, 0);

        // host read interleaved in WAIT_TI
        ti_auto = 1'b0;
        b = 8'($urandom);
        push_byte(b, 1'b0, n);
        get_acc("hr_trs", 10, e);
        chk("hr_trs_acc", {e.w, e.a, e.d}, {1'b1, TRS, mq.pop_front()});
        host_go(1'b0, 16'h0014, 8'h00, h);
        get_acc("hr_rd", 10, e);
        chk("hr_rd_acc", {e.w, e.a}, {1'b0, 16'h0014});
        chk("hr_rd_lat", e.c - h, 2);
        wait_ack("hr_ack", ac);
        chk("hr_ack_lat", ac - h, 3);
        chk("hr_rdata", host_rdata, 8'h21);
        ti_at = cyc;
        t0 = cyc;
        get_acc("hr_clr", 10, e);
        chk("hr_clr_acc", {e.w, e.a, e.d}, {1'b1, INTR, 8'h00});
        chk("hr_clr_lat", e.c - t0, 1);
        chk("hr_no_tmo", timeout_err, 0);

        // timeout then next byte, then flush
        tick(4);
        stream_en = 1'b0;
        push_byte(8'($urandom), 1'b1, n);
        push_byte(8'($urandom), 1'b1, n);
        stream_en = 1'b1;
        get_acc("to_trs1", 10, e);
        chk("to_trs1_data", e.d, mq.pop_front());
        t0 = e.c;
        ti_auto = 1'b1;
        ti_delay = 3;
        get_acc("to_clr1", 40, e);
        chk("to_clr1_acc", {e.w, e.a, e.d}, {1'b1, INTR, 8'h00});
        chk("to_clr1_cycles", e.c - t0, 21);
        chk("to_err_set", timeout_err, 1);
        get_acc("to_trs2", 10, e);
        chk("to_trs2_data", e.d, mq.pop_front());
        t0 = e.c;
        get_acc("to_clr2", 20, e);
        chk("to_clr2_lat", e.c - t0, 4);
        chk("to_err_sticky", timeout_err, 1);
        stream_en = 1'b0;
        tick(3);
        push_byte(8'($urandom), 1'b1, n);
        push_byte(8'($urandom), 1'b1, n);
        flush = 1'b1;
        mq.delete();
        tick(1);
        flush = 1'b0;
        chk("flush_err", timeout_err, 0);
        chk("flush_cnt", fifo_cnt, 0);

        // host_req + push + flush in one idle cycle
        stream_en = 1'b1;
        b = 8'($urandom);
        s_valid = 1'b1;
        s_data = 8'($urandom);
        flush = 1'b1;
        host_go(1'b1, 16'h0020, b, h);
        s_valid = 1'b0;
        flush = 1'b0;
        chk("sim_fifo_empty", fifo_cnt, 0);
        get_acc("sim_host", 10, e);
        chk("sim_host_acc", {e.w, e.a, e.d}, {1'b1, 16'h0020, b});
        chk("sim_host_lat", e.c - h, 2);
        wait_ack("sim_ack", ac);
        chk("sim_ack_lat", ac - h, 3);
        tick(10);
        chk("sim_no_trs", log_q.size() - rd_idx, 0);

        // reset during WAIT_TI
        ti_auto = 1'b0;
        stream_en = 1'b0;
        push_byte(8'($urandom), 1'b1, n);
        push_byte(8'($urandom), 1'b1, n);
        stream_en = 1'b1;
        get_acc("rst_trs", 10, e);
        chk("rst_trs_data", e.d, mq.pop_front());
        chk("rst_busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid_vals");
        mq.delete();
        tick(2);
        reset_n = 1'b1;
        tick(25);
        chk("rst_no_access", log_q.size() - rd_idx, 0);
        chk("rst_cnt_after", fifo_cnt, 0);
        chk("rst_busy_after", busy, 0);

        chk("port_protocol", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
